// File: rtl/ram_pkg.sv
// Shared types and constants for the clearable single-port RAM.
// Imported by the storage array and the top-level controller.
package ram_pkg;

    localparam int RDW_READ_FIRST  = 0;
    localparam int RDW_WRITE_FIRST = 1;

    typedef enum logic {
        CLEAR = 1'b0,
        IDLE  = 1'b1
    } ram_state_t;

endpackage

// File: rtl/ram_sp_array.sv
// Unreset storage array with one write port and a registered read port.
// The read port resolves same-address read-during-write by RDW_MODE.
module ram_sp_array
    import ram_pkg::*;
#(
    parameter int DATA_W   = 4,
    parameter int ADDR_W   = 2,
    parameter int RDW_MODE = RDW_READ_FIRST
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic              re,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out,
    output logic              rd_valid
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    // Contents are defined only by the clear sweep, so no reset here.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[address] <= data_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_out <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= re;
            if (re) begin
                if (RDW_MODE == RDW_WRITE_FIRST && we) begin
                    data_out <= data_in;
                end else begin
                    data_out <= mem[address];
                end
            end
        end
    end

endmodule

// File: rtl/sync_ram_clr.sv
// Single-port synchronous RAM with a hardware clear sweep after reset
// or on request; owns the FSM, sweep counter and write-port arbitration.
module sync_ram_clr
    import ram_pkg::*;
#(
    parameter int                 DATA_W   = 4,
    parameter int                 ADDR_W   = 2,
    parameter int                 RDW_MODE = RDW_READ_FIRST,
    parameter logic [DATA_W-1:0]  CLR_VAL  = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic              re,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] data_in,
    input  logic              clr,
    output logic [DATA_W-1:0] data_out,
    output logic              rd_valid,
    output logic              busy
);

    ram_state_t        state;
    ram_state_t        next_state;
    logic [ADDR_W-1:0] clr_addr;
    logic [ADDR_W-1:0] next_clr_addr;

    logic              arr_we;
    logic              arr_re;
    logic [ADDR_W-1:0] arr_addr;
    logic [DATA_W-1:0] arr_din;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= CLEAR;
            clr_addr <= '0;
        end else begin
            state    <= next_state;
            clr_addr <= next_clr_addr;
        end
    end

    always_comb begin
        next_state    = state;
        next_clr_addr = clr_addr;
        unique case (state)
            CLEAR: begin
                if (&clr_addr) begin
                    next_state    = IDLE;
                    next_clr_addr = '0;
                end else begin
                    next_clr_addr = clr_addr + ADDR_W'(1);
                end
            end
            IDLE: begin
                if (clr) begin
                    next_state = CLEAR;
                end
            end
            default: begin
                next_state = CLEAR;
            end
        endcase
    end

    assign busy = (state == CLEAR);

    // The sweep owns the single port; user requests are dropped meanwhile.
    assign arr_we   = busy | we;
    assign arr_re   = ~busy & re;
    assign arr_addr = busy ? clr_addr : address;
    assign arr_din  = busy ? CLR_VAL : data_in;

    ram_sp_array #(
        .DATA_W  (DATA_W),
        .ADDR_W  (ADDR_W),
        .RDW_MODE(RDW_MODE)
    ) u_array (
        .clk     (clk),
        .rst_n   (rst_n),
        .we      (arr_we),
        .re      (arr_re),
        .address (arr_addr),
        .data_in (arr_din),
        .data_out(data_out),
        .rd_valid(rd_valid)
    );

endmodule

// File: tb/tb_sync_ram_clr.sv
// Bench for sync_ram_clr: a 4x4 read-first instance and a 16x8
// write-first instance share one stimulus stream against a reference model.
module tb_sync_ram_clr;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       we = 1'b0;
    logic       re = 1'b0;
    logic       clr = 1'b0;
    logic [3:0] address = '0;
    logic [7:0] data_in = '0;

    logic [3:0] do_a;
    logic       rv_a;
    logic       busy_a;
    logic [7:0] do_b;
    logic       rv_b;
    logic       busy_b;

    sync_ram_clr u_a (
        .clk     (clk),
        .rst_n   (rst_n),
        .we      (we),
        .re      (re),
        .address (address[1:0]),
        .data_in (data_in[3:0]),
        .clr     (clr),
        .data_out(do_a),
        .rd_valid(rv_a),
        .busy    (busy_a)
    );

    sync_ram_clr #(
        .DATA_W  (8),
        .ADDR_W  (4),
        .RDW_MODE(1),
        .CLR_VAL (8'h5A)
    ) u_b (
        .clk     (clk),
        .rst_n   (rst_n),
        .we      (we),
        .re      (re),
        .address (address),
        .data_in (data_in),
        .clr     (clr),
        .data_out(do_b),
        .rd_valid(rv_b),
        .busy    (busy_b)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: index 0 is u_a, index 1 is u_b.
    int         depth [2] = '{4, 16};
    logic [7:0] mask  [2] = '{8'h0F, 8'hFF};
    logic [7:0] clrv  [2] = '{8'h00, 8'h5A};
    int         mode  [2] = '{0, 1};
    logic [7:0] m     [2][16];
    int         left  [2];
    logic [7:0] edo   [2];
    logic       erv   [2];

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic model_edge();
        for (int i = 0; i < 2; i++) begin
            int         a;
            logic [7:0] d;
            erv[i] = 1'b0;
            if (left[i] > 0) begin
                m[i][depth[i] - left[i]] = clrv[i];
                left[i]--;
            end else begin
                a = int'(address) % depth[i];
                d = data_in & mask[i];
                if (re) begin
                    edo[i] = (mode[i] == 1 && we) ? d : m[i][a];
                    erv[i] = 1'b1;
                end
                if (we) m[i][a] = d;
                if (clr) left[i] = depth[i];
            end
        end
    endtask

    task automatic check_all();
        chk("a_data", 64'(do_a), 64'(edo[0]));
        chk("a_valid", 64'(rv_a), 64'(erv[0]));
        chk("a_busy", 64'(busy_a), 64'(left[0] > 0));
        chk("b_data", 64'(do_b), 64'(edo[1]));
        chk("b_valid", 64'(rv_b), 64'(erv[1]));
        chk("b_busy", 64'(busy_b), 64'(left[1] > 0));
    endtask

    task automatic step(input logic w, input logic r, input logic c,
                        input logic [3:0] a, input logic [7:0] d);
        we      = w;
        re      = r;
        clr     = c;
        address = a;
        data_in = d;
        @(posedge clk);
        #1;
        model_edge();
        check_all();
    endtask

    task automatic do_reset();
        #3;
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            left[i] = depth[i];
            edo[i]  = 8'h00;
            erv[i]  = 1'b0;
        end
        check_all();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic       w;
        logic       r;
        logic       c;
        logic [3:0] a;
        logic [7:0] d;
        logic [3:0] exp_do;
        logic       exp_rv;
        logic       exp_busy;
    } vec_t;

    vec_t tv[16];
    int   bn;

    initial begin
        for (int i = 0; i < 2; i++)
            for (int k = 0; k < 16; k++) m[i][k] = 'x;

        // Expectations for the 4x4 read-first instance after each edge.
        tv[0]  = '{0, 0, 0, 0, 8'h0, 4'h0, 0, 1};
        tv[1]  = '{0, 0, 0, 0, 8'h0, 4'h0, 0, 1};
        tv[2]  = '{0, 0, 0, 0, 8'h0, 4'h0, 0, 1};
        tv[3]  = '{0, 0, 0, 0, 8'h0, 4'h0, 0, 0};
        tv[4]  = '{0, 1, 0, 0, 8'h0, 4'h0, 1, 0};
        tv[5]  = '{0, 1, 0, 1, 8'h0, 4'h0, 1, 0};
        tv[6]  = '{0, 1, 0, 2, 8'h0, 4'h0, 1, 0};
        tv[7]  = '{0, 1, 0, 3, 8'h0, 4'h0, 1, 0};
        tv[8]  = '{0, 0, 0, 0, 8'h0, 4'h0, 0, 0};
        tv[9]  = '{1, 0, 0, 2, 8'hA, 4'h0, 0, 0};
        tv[10] = '{0, 1, 0, 2, 8'h0, 4'hA, 1, 0};
        tv[11] = '{1, 0, 0, 1, 8'h3, 4'hA, 0, 0};
        tv[12] = '{1, 1, 0, 1, 8'h7, 4'h3, 1, 0};
        tv[13] = '{0, 1, 0, 1, 8'h0, 4'h7, 1, 0};
        tv[14] = '{0, 0, 0, 0, 8'h0, 4'h7, 0, 0};
        tv[15] = '{0, 0, 0, 0, 8'h0, 4'h7, 0, 0};

        do_reset();

        for (int t = 0; t < 16; t++) begin
            step(tv[t].w, tv[t].r, tv[t].c, tv[t].a, tv[t].d);
            chk($sformatf("tbl%0d_do", t), 64'(do_a), 64'(tv[t].exp_do));
            chk($sformatf("tbl%0d_rv", t), 64'(rv_a), 64'(tv[t].exp_rv));
            chk($sformatf("tbl%0d_busy", t), 64'(busy_a),
                64'(tv[t].exp_busy));
        end

        // Same-address read-during-write on both instances.
        step(1, 0, 0, 4'd1, 8'h03);
        step(1, 1, 0, 4'd1, 8'h07);
        chk("a_read_first", 64'(do_a), 64'h3);
        chk("b_write_first", 64'(do_b), 64'h07);
        step(0, 1, 0, 4'd1, 8'h00);
        chk("a_after_rdw", 64'(do_a), 64'h7);

        // Fill, clear, and hammer the port while the sweep runs.
        for (int k = 0; k < 16; k++)
            step(1, 0, 0, 4'(k), 8'($urandom));
        step(0, 0, 1, 4'd0, 8'h00);
        bn = 0;
        for (int c = 0; c < 40 && busy_b; c++) begin
            bn++;
            step(1'($urandom), 1'($urandom), 1'b0,
                 4'($urandom), 8'($urandom));
        end
        chk("b_clr_busy_len", 64'(bn), 64'd16);
        for (int k = 0; k < 16; k++) begin
            step(0, 1, 0, 4'(k), 8'h00);
            chk("b_clr_val", 64'(do_b), 64'h5A);
        end

        // Reset while the sweep sits at clr_addr = 5.
        for (int k = 0; k < 16; k++)
            step(1, 0, 0, 4'(k), 8'($urandom));
        step(0, 1, 1, 4'd2, 8'h00);
        for (int k = 0; k < 5; k++)
            step(0, 1, 0, 4'(k), 8'h00);
        do_reset();
        bn = 0;
        for (int c = 0; c < 40 && busy_b; c++) begin
            bn++;
            step(1'($urandom), 1'($urandom), 1'b0,
                 4'($urandom), 8'($urandom));
        end
        chk("b_rst_busy_len", 64'(bn), 64'd16);
        for (int k = 0; k < 16; k++) begin
            step(0, 1, 0, 4'(k), 8'h00);
            chk("b_rst_clr_val", 64'(do_b), 64'h5A);
        end

        for (int n = 0; n < 500; n++) begin
            step(1'($urandom), 1'($urandom), ($urandom % 32) == 0,
                 4'($urandom), 8'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
